// File: rtl/ook_framer_if.sv
// Byte stream into the OOK framer: data_in qualified by data_valid,
// accepted when data_ready is also high at a rising clock edge.
interface ook_framer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/ook_framer.sv
// OOK bit framer: turns accepted bytes into a keying bit stream for the DDS.
// A burst is an alternating preamble, data bytes MSB first, then a silent gap.
// A byte offered on the last cycle of the previous byte streams on directly.
module ook_framer #(
  parameter int BIT_PERIOD   = 1000,
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_BITS     = 2
) (
  input  logic         clk,
  input  logic         rst,
  ook_framer_if.slave  bus,
  output logic         ook_data,
  output logic         busy,
  output logic         frame_done
);

  localparam int CYC_W     = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam int IDX_MAX_A = (PREAMBLE_LEN > 8) ? PREAMBLE_LEN : 8;
  localparam int IDX_MAX   = (GAP_BITS > IDX_MAX_A) ? GAP_BITS : IDX_MAX_A;
  // bit_idx holds 0..IDX_MAX-1, so this is the width of (max value + 1)
  localparam int IDX_W     = $clog2(IDX_MAX);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_PERIOD - 1);
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(PREAMBLE_LEN - 1);
  localparam logic [IDX_W-1:0] GAP_LAST  = IDX_W'(GAP_BITS - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(7);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [CYC_W-1:0]   cyc_reg, cyc_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;   // bits remaining in phase after the current one
  logic [7:0]         shift_reg, shift_next;
  logic               ook_reg, ook_next;
  logic               busy_reg;

  logic bit_end;
  logic last_bit;
  logic ready;
  logic take;

  // Handshake: ready in IDLE, or on the very last cycle of a byte so a waiting byte streams on
  always_comb begin
    bit_end  = (cyc_reg == CYC_LAST);
    last_bit = (idx_reg == '0);
    ready    = rst && ((state_reg == IDLE) ||
                       (state_reg == DATA && last_bit && bit_end));
    take     = bus.data_valid && ready;
  end

  assign bus.data_ready = ready;

  // Next-state, counters and shift register
  always_comb begin
    state_next = state_reg;
    cyc_next   = cyc_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;

    if (state_reg != IDLE) begin
      cyc_next = bit_end ? '0 : cyc_reg + CYC_W'(1);
    end

    unique case (state_reg)
      IDLE: begin
        cyc_next = '0;
        if (take) begin
          shift_next = bus.data_in;
          if (PREAMBLE_LEN > 0) begin
            state_next = PREAMBLE;
            idx_next   = PRE_LAST;
          end else begin
            state_next = DATA;
            idx_next   = DATA_LAST;
          end
        end
      end
      PREAMBLE: begin
        if (bit_end) begin
          if (last_bit) begin
            state_next = DATA;
            idx_next   = DATA_LAST;
          end else begin
            idx_next = idx_reg - IDX_W'(1);
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (!last_bit) begin
            idx_next   = idx_reg - IDX_W'(1);
            shift_next = {shift_reg[6:0], 1'b0};
          end else if (take) begin
            shift_next = bus.data_in;
            idx_next   = DATA_LAST;
          end else if (GAP_BITS > 0) begin
            state_next = GAP;
            idx_next   = GAP_LAST;
          end else begin
            state_next = IDLE;
            idx_next   = '0;
          end
        end
      end
      GAP: begin
        if (bit_end) begin
          if (last_bit) begin
            state_next = IDLE;
          end else begin
            idx_next = idx_reg - IDX_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Keying bit for the next cycle; preamble bit k = PRE_LAST - idx, driven as ~k[0]
  always_comb begin
    ook_next = 1'b0;
    unique case (state_next)
      PREAMBLE: ook_next = ~(PRE_LAST[0] ^ idx_next[0]);
      DATA:     ook_next = shift_next[7];
      default:  ook_next = 1'b0;
    endcase
  end

  // End-of-burst pulse: last gap cycle, or last data cycle with no byte following when there is no gap
  always_comb begin
    frame_done = rst && bit_end && last_bit &&
                 ((state_reg == GAP) ||
                  ((GAP_BITS == 0) && (state_reg == DATA) && !take));
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      cyc_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      ook_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cyc_reg   <= cyc_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      ook_reg   <= ook_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  assign ook_data = ook_reg;
  assign busy     = busy_reg;

endmodule

// File: tb/tb_ook_framer.sv
// Bench for ook_framer: a cycle-level waveform model plus a byte scoreboard
// that decodes ook_data back into bytes; a second instance covers the
// BIT_PERIOD=1 / no preamble / no gap corner.
module tb_ook_framer;
  localparam int BP  = 4;
  localparam int PRE = 4;
  localparam int GAP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  ook_framer_if bus();
  ook_framer_if bus5();
  logic ook_data, busy, frame_done;
  logic ook5, busy5, fd5;

  ook_framer #(.BIT_PERIOD(BP), .PREAMBLE_LEN(PRE), .GAP_BITS(GAP)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ook_data(ook_data), .busy(busy), .frame_done(frame_done)
  );

  ook_framer #(.BIT_PERIOD(1), .PREAMBLE_LEN(0), .GAP_BITS(0)) dut5 (
    .clk(clk), .rst(rst), .bus(bus5),
    .ook_data(ook5), .busy(busy5), .frame_done(fd5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  typedef struct packed {
    logic ook;
    logic rdy;
    logic fd;
  } ent_t;

  ent_t       wave_q[$];     // expected outputs, one entry per future cycle
  logic [7:0] exp_bytes[$];  // accepted bytes awaiting decode
  bit         bits[$];
  int         dcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void add_bit(input logic b, input logic rdy, input logic fd);
    ent_t e;
    for (int c = 0; c < BP; c++) begin
      e.ook = b;
      e.rdy = rdy && (c == BP - 1);
      e.fd  = fd && (c == BP - 1);
      wave_q.push_back(e);
    end
  endfunction

  function automatic void add_byte(input logic [7:0] b, input bit with_pre);
    if (with_pre)
      for (int k = 0; k < PRE; k++) add_bit(k % 2 == 0, 1'b0, 1'b0);
    for (int i = 7; i >= 0; i--) add_bit(b[i], i == 0, (GAP == 0) && (i == 0));
    for (int g = 0; g < GAP; g++) add_bit(1'b0, 1'b0, g == GAP - 1);
  endfunction

  // Waveform model: compare every output each cycle, then advance by the handshake outcome
  always @(negedge clk) begin : model
    ent_t h;
    bit   have;
    logic e_rdy, e_fd, take;
    if (chk_en) begin
      have  = (wave_q.size() != 0);
      h     = have ? wave_q[0] : '0;
      e_rdy = rst && (!have || h.rdy);
      take  = bus.data_valid && e_rdy;
      e_fd  = rst && have && h.fd && !((GAP == 0) && take);
      chk("ook_data",   ook_data,       have ? h.ook : 1'b0);
      chk("busy",       busy,           have);
      chk("data_ready", bus.data_ready, e_rdy);
      chk("frame_done", frame_done,     e_fd);
      if (!rst) begin
        wave_q.delete();
        exp_bytes.delete();
      end else begin
        if (have) void'(wave_q.pop_front());
        if (take) begin
          if (have) wave_q.delete();  // back-to-back: remaining gap is replaced by the new byte
          add_byte(bus.data_in, !have);
          exp_bytes.push_back(bus.data_in);
        end
      end
    end
  end

  task automatic decode_frame();
    int         nb;
    int         nbytes;
    bit         ok;
    logic [31:0] pg, pe;
    logic [7:0] got, e;
    logic       gg;
    nb = bits.size();
    ok = (nb >= PRE + GAP) && (((nb - PRE - GAP) % 8) == 0);
    chk("frame_len", {31'd0, ok}, 32'd1);
    if (ok) begin
      pg = '0;
      pe = '0;
      for (int k = 0; k < PRE; k++) begin
        pg[k] = bits[k];
        pe[k] = (k % 2 == 0);
      end
      chk("preamble", pg, pe);
      nbytes = (nb - PRE - GAP) / 8;
      for (int j = 0; j < nbytes; j++) begin
        for (int i = 0; i < 8; i++) got[7 - i] = bits[PRE + 8 * j + i];
        if (exp_bytes.size() == 0) begin
          chk("byte_expected", 32'd0, 32'd1);
        end else begin
          e = exp_bytes.pop_front();
          chk("byte", {24'd0, got}, {24'd0, e});
          $display("tb: byte %02h decoded (expected %02h) at %0t", got, e, $time);
        end
      end
      gg = 1'b0;
      for (int g = 0; g < GAP; g++) gg = gg | bits[nb - GAP + g];
      chk("gap_zero", {31'd0, gg}, 32'd0);
    end
  endtask

  // Byte scoreboard: sample mid-bit while busy, decode when the burst ends
  always begin : decoder
    @(negedge clk);
    #1;
    if (!chk_en || !rst) begin
      bits.delete();
      dcnt = 0;
    end else if (busy) begin
      if (dcnt % BP == BP / 2) bits.push_back(ook_data);
      dcnt++;
    end else if (dcnt > 0) begin
      decode_frame();
      bits.delete();
      dcnt = 0;
    end
  end

  task automatic send(input logic [7:0] b);
    int waited;
    waited = 0;
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.data_ready) break;
      waited++;
      if (waited > 200) begin
        chk("send_accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (busy && w < 500);
    chk("idle_reached", {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] b5;
    rst             = 1'b0;
    bus.data_in     = 8'h00;
    bus.data_valid  = 1'b0;
    bus5.data_in    = 8'h00;
    bus5.data_valid = 1'b0;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    // single byte with preamble and gap
    send(8'hA5);
    wait_idle();

    // valid held across two bytes: second streams on without preamble
    send(8'hFF);
    send(8'h00);
    wait_idle();

    // valid raised during the gap: held off until idle, then a full preamble
    send(8'h3C);
    repeat (50) @(posedge clk);
    #1;
    send(8'hC3);
    wait_idle();

    // reset mid-data with a byte offered during reset
    send(8'h5A);
    repeat (29) @(posedge clk);
    #1;
    rst            = 1'b0;
    bus.data_in    = 8'h77;
    bus.data_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h77);
    wait_idle();

    // BIT_PERIOD=1, no preamble, no gap
    b5              = 8'h81;
    bus5.data_in    = b5;
    bus5.data_valid = 1'b1;
    @(negedge clk);
    chk("t5_ready_idle", {31'd0, bus5.data_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus5.data_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t5_ook",   {31'd0, ook5},  {31'd0, b5[8 - i]});
      chk("t5_busy",  {31'd0, busy5}, 32'd1);
      chk("t5_fd",    {31'd0, fd5},   {31'd0, i == 8});
      chk("t5_ready", {31'd0, bus5.data_ready}, {31'd0, i == 8});
    end
    @(negedge clk);
    chk("t5_busy_end", {31'd0, busy5}, 32'd0);
    chk("t5_ook_end",  {31'd0, ook5},  32'd0);
    chk("t5_fd_end",   {31'd0, fd5},   32'd0);
    @(posedge clk);
    #1;

    // random bytes with random valid gaps
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.data_valid = 1'b0;
        repeat ($urandom_range(1, 40)) @(posedge clk);
        #1;
      end
      send(8'($urandom_range(0, 255)));
    end
    wait_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("bytes_outstanding", exp_bytes.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
